i2c_axil_regs: RTL and testbench
================================

# i2c_axil_regs

AXI4-Lite responder (slave) register file for the i2c_wyf peripheral: it accepts single-beat write and read transactions from the AXI4-Lite master/BFM and holds four 32-bit software-visible registers. It sits between the AXI interconnect and the I2C core. The core receives a one-cycle command strobe on every write to register 0.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- ACLK  in  1  sole clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte lane enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data handshake.
- cmd_strobe  out  1  one-cycle pulse after a write to register 0 commits.
- cmd_word  out  32  current value of register 0; continuously driven.

## Operation
- Registers: slv_reg0..slv_reg3, all read/write, all reset to 0.
- Write channel has two states, W_IDLE and W_RESP.
  - In W_IDLE, when AWVALID and WVALID are both 1, AWREADY and WREADY pulse high together for 1 cycle. The register update happens on that same edge, and the state moves to W_RESP with BVALID=1.
  - AWVALID alone, or WVALID alone, is never accepted. The responder waits until both are present.
  - In W_RESP, BVALID holds until BREADY=1, then the state returns to W_IDLE. No new AW/W is accepted while in W_RESP.
- Read channel has two states, R_IDLE and R_DATA.
  - In R_IDLE with ARVALID=1, ARREADY pulses for 1 cycle. RDATA is captured from the addressed register and RVALID=1 next cycle.
  - RDATA and RVALID hold until RREADY=1, then the state returns to R_IDLE.
- The read and write channels are fully independent and may handshake in the same cycle.
- If a read and a write to the same register handshake in the same cycle, the read returns the pre-write value.
- cmd_strobe goes high for exactly 1 cycle, the cycle after the handshake of any write with address[3:2]=0. This includes writes whose WSTRB is all zero.
- Back-to-back writes to register 0 produce one strobe per write.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID and cmd_strobe are 0; BRESP, RRESP, RDATA and cmd_word are 0.
- Write latency: handshake at cycle N; BVALID and cmd_strobe high at N+1. The earliest next write handshake is 1 cycle after BVALID&BREADY.
- Read latency: ARREADY at cycle N; RVALID at N+1.
- Maximum throughput is one transaction per 2 cycles per channel, with the master holding READY high.
- ARESET asserted mid-transaction:
  - All VALID/READY outputs drop to 0 on the next edge.
  - Registers clear, and the pending response is discarded.
  - Both state machines return to IDLE.

## Configuration
- I2C_AXIL_WSTRB_EN defined: each byte lane i of the register is written only when WSTRB[i]=1.
- Not defined: WSTRB is ignored and every write updates all 32 bits.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0. Reading addresses 0x0, 0x4, 0x8 and 0xC returns 0x00000000 with RRESP=00.
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC, then read each back -> every read matches, BRESP=RRESP=00, and cmd_strobe pulses exactly once (on the 0x0 write) with cmd_word=0x0101FFFF.
- Present AWVALID 3 cycles before WVALID -> AWREADY stays 0 until WVALID rises. Both READYs then pulse in the same cycle and BVALID follows 1 cycle later.
- Hold BREADY=0 for 5 cycles after a write -> BVALID holds and no second write is accepted. Apply the same test to RVALID/RDATA with RREADY=0.
- Set reg1=0x11111111, then write 0xAABBCCDD with WSTRB=4'b0101 -> with I2C_AXIL_WSTRB_EN reg1 reads 0x11BB11DD; without it, 0xAABBCCDD.
- Issue a simultaneous write of 0x12345678 and a read to 0x8 when reg2=0xDEAD0011 -> the read returns 0xDEAD0011 and a subsequent read returns 0x12345678. Then assert ARESET while BVALID=1 -> BVALID=0 next cycle and reg2 reads 0.

Source files
------------

// File: rtl/i2c_axil_regs.sv
// i2c_axil_regs: AXI4-Lite register file for the i2c_wyf core.
// Define I2C_AXIL_WSTRB_EN to honour WSTRB byte lanes on writes.
module i2c_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            cmd_strobe,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_word
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg [4];
    logic [1:0] w_sel;
    logic [1:0] r_sel;
    logic       w_hs;
    logic       r_hs;
    logic       unused_in;

    // Protection bits, low address bits and (when lanes are ignored) WSTRB carry no meaning here
    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR,
                         S_AXI_ARADDR, S_AXI_WSTRB};

    assign w_sel = S_AXI_AWADDR[3:2];
    assign r_sel = S_AXI_ARADDR[3:2];

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign cmd_word    = slv_reg[0];

    // Write channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write channel: accept AW and W only together, then hold the response
    always_comb begin
        w_next        = w_state;
        w_hs          = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
                    w_hs          = 1'b1;
                    S_AXI_AWREADY = 1'b1;
                    S_AXI_WREADY  = 1'b1;
                    w_next        = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    w_next = W_IDLE;
                end
            end
        endcase
    end

    // Read channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read channel: accept an address, then hold the data until taken
    always_comb begin
        r_next        = r_state;
        r_hs          = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID && !ARESET) begin
                    r_hs          = 1'b1;
                    S_AXI_ARREADY = 1'b1;
                    r_next        = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    r_next = R_IDLE;
                end
            end
        endcase
    end

    // Register file update on the write handshake edge
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                slv_reg[i] <= '0;
            end
        end else if (w_hs) begin
`ifdef I2C_AXIL_WSTRB_EN
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    slv_reg[w_sel][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
`else
            slv_reg[w_sel] <= S_AXI_WDATA;
`endif
        end
    end

    // Read data capture; sees the pre-write value on a same-cycle write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_RDATA <= '0;
        end else if (r_hs) begin
            S_AXI_RDATA <= slv_reg[r_sel];
        end
    end

    // One-cycle command pulse for every write to register 0, whatever the lanes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_strobe <= 1'b0;
        end else begin
            cmd_strobe <= w_hs && (w_sel == 2'd0);
        end
    end

endmodule

// File: tb/tb_i2c_axil_regs.sv
// tb_i2c_axil_regs: directed bench for the i2c_axil_regs register file.
// Expected values depend on I2C_AXIL_WSTRB_EN in the WSTRB step only.
module tb_i2c_axil_regs;

    logic        tb_ACLK = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        cmd_strobe;
    logic [31:0] cmd_word;

    int checks = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int s0;

    // 100 MHz-style free-running clock
    always #5 tb_ACLK = ~tb_ACLK;

    // Count cycles in which the command strobe is high
    always @(negedge tb_ACLK) begin
        if (cmd_strobe) strobe_cnt++;
    end

    i2c_axil_regs dut (
        .ACLK          (tb_ACLK),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .cmd_strobe    (cmd_strobe),
        .cmd_word      (cmd_word)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the channel idle
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n;
        n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        while (!(awready && wready) && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        chk("w_accept", {31'b0, n < 20}, 32'd1);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w_bvalid", {31'b0, bvalid}, 32'd1);
        chk("w_bresp", {30'b0, bresp}, 32'd0);
        @(negedge tb_ACLK);
        chk("w_bdone", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        while (!arready && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        chk("r_accept", {31'b0, n < 20}, 32'd1);
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        chk("r_rvalid", {31'b0, rvalid}, 32'd1);
        chk("r_rresp", {30'b0, rresp}, 32'd0);
        d = rdata;
        @(negedge tb_ACLK);
        chk("r_rdone", {31'b0, rvalid}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] wstrb_exp;
        logic [31:0] zero_strb_exp;
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        areset = 1'b0;
        repeat (10) @(negedge tb_ACLK);

        // Reset state
        chk("rst_ctl", {26'b0, awready, wready, bvalid, arready,
                        rvalid, cmd_strobe}, 32'd0);
        chk("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_cmd_word", cmd_word, 32'd0);
        rd_chk("rst_reg0", 4'h0, 32'h0);
        rd_chk("rst_reg1", 4'h4, 32'h0);
        rd_chk("rst_reg2", 4'h8, 32'h0);
        rd_chk("rst_reg3", 4'hC, 32'h0);

        // Basic write / read-back of all four registers
        s0 = strobe_cnt;
        axi_write(4'h0, 32'h0101FFFF, 4'hF);
        axi_write(4'h4, 32'hABCD0001, 4'hF);
        axi_write(4'h8, 32'hDEAD0011, 4'hF);
        axi_write(4'hC, 32'hBEEF0011, 4'hF);
        rd_chk("rb_reg0", 4'h0, 32'h0101FFFF);
        rd_chk("rb_reg1", 4'h4, 32'hABCD0001);
        rd_chk("rb_reg2", 4'h8, 32'hDEAD0011);
        rd_chk("rb_reg3", 4'hC, 32'hBEEF0011);
        chk("rb_strobes", 32'(strobe_cnt - s0), 32'd1);
        chk("rb_cmd_word", cmd_word, 32'h0101FFFF);

        // AWVALID three cycles ahead of WVALID
        awaddr = 4'h4; wdata = 32'h22222222; wstrb = 4'hF;
        awvalid = 1'b1; bready = 1'b1;
        repeat (3) begin
            @(negedge tb_ACLK);
            chk("aw_only_rdy", {30'b0, awready, wready}, 32'd0);
        end
        wvalid = 1'b1;
        #1;
        chk("aw_w_rdy", {30'b0, awready, wready}, 32'd3);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw_w_bvalid", {31'b0, bvalid}, 32'd1);
        @(negedge tb_ACLK);
        chk("aw_w_bdone", {31'b0, bvalid}, 32'd0);
        rd_chk("aw_w_reg1", 4'h4, 32'h22222222);

        // BREADY low for 5 cycles with a second write waiting
        awaddr = 4'hC; wdata = 32'h33333333; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        chk("bh_rdy", {30'b0, awready, wready}, 32'd3);
        @(negedge tb_ACLK);
        wdata = 32'h44444444;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bh_bvalid", {31'b0, bvalid}, 32'd1);
            chk("bh_block", {30'b0, awready, wready}, 32'd0);
            @(negedge tb_ACLK);
        end
        bready = 1'b1;
        @(negedge tb_ACLK);
        chk("bh_bdone", {31'b0, bvalid}, 32'd0);
        chk("bh_next_rdy", {30'b0, awready, wready}, 32'd3);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bh_bvalid2", {31'b0, bvalid}, 32'd1);
        @(negedge tb_ACLK);
        chk("bh_bdone2", {31'b0, bvalid}, 32'd0);

        // RREADY low for 5 cycles with a second read waiting
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        #1;
        chk("rh_arready", {31'b0, arready}, 32'd1);
        @(negedge tb_ACLK);
        araddr = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rh_rvalid", {31'b0, rvalid}, 32'd1);
            chk("rh_rdata", rdata, 32'h44444444);
            chk("rh_block", {31'b0, arready}, 32'd0);
            @(negedge tb_ACLK);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge tb_ACLK);
        chk("rh_rdone", {31'b0, rvalid}, 32'd0);

        // Byte-lane write on reg1
`ifdef I2C_AXIL_WSTRB_EN
        wstrb_exp = 32'h11BB11DD;
        zero_strb_exp = 32'h00000001;
`else
        wstrb_exp = 32'hAABBCCDD;
        zero_strb_exp = 32'h00000002;
`endif
        axi_write(4'h4, 32'h11111111, 4'hF);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101);
        rd_chk("wstrb_reg1", 4'h4, wstrb_exp);

        // Back-to-back writes to reg0, the second with no lanes enabled
        s0 = strobe_cnt;
        axi_write(4'h0, 32'h00000001, 4'hF);
        axi_write(4'h0, 32'h00000002, 4'h0);
        @(negedge tb_ACLK);
        chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd2);
        chk("b2b_cmd_word", cmd_word, zero_strb_exp);

        // Simultaneous write and read of reg2
        awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b1;
        #1;
        chk("sim_rdy", {30'b0, awready, arready}, 32'd3);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("sim_valids", {30'b0, bvalid, rvalid}, 32'd3);
        chk("sim_old_data", rdata, 32'hDEAD0011);
        @(negedge tb_ACLK);
        chk("sim_done", {30'b0, bvalid, rvalid}, 32'd0);
        rd_chk("sim_new_data", 4'h8, 32'h12345678);

        // Reset while a write response is pending
        awaddr = 4'h8; wdata = 32'h55555555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("mr_bvalid", {31'b0, bvalid}, 32'd1);
        areset = 1'b1;
        @(negedge tb_ACLK);
        chk("mr_ctl", {26'b0, awready, wready, bvalid, arready,
                       rvalid, cmd_strobe}, 32'd0);
        chk("mr_cmd_word", cmd_word, 32'd0);
        areset = 1'b0; bready = 1'b1;
        @(negedge tb_ACLK);
        chk("mr_bvalid_off", {31'b0, bvalid}, 32'd0);
        rd_chk("mr_reg2", 4'h8, 32'h0);
        rd_chk("mr_reg1", 4'h4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
